// File: rtl/hcsr04_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// hcsr04_scheduler_pkg
// Shared definitions for the HC-SR04 measurement controller and its datapath:
// the 4-bit state codes reported on db_estado and the default timing
// constants for a 50 MHz system clock.
// -----------------------------------------------------------------------------
package hcsr04_scheduler_pkg;

  localparam int CLK_HZ      = 50_000_000;
  // 10 us trigger pulse
  localparam int T_TRIGGER   = CLK_HZ / 100_000;
  // 40 ms limit for the echo to start and finish
  localparam int TIMEOUT_ECO = CLK_HZ / 25;
  // 60 ms mandatory pause between measurements
  localparam int INTERVALO   = (CLK_HZ / 100) * 6;
  localparam int CW          = 22;
  localparam int EST_W       = 4;

  typedef enum logic [EST_W-1:0] {
    ST_INICIAL    = 4'h0,
    ST_PREPARA    = 4'h1,
    ST_TRIGGER    = 4'h2,
    ST_ESPERA_ECO = 4'h3,
    ST_MEDIDA     = 4'h4,
    ST_ARMAZENA   = 4'h5,
    ST_FINAL      = 4'h6,
    ST_INTERVALO  = 4'h7,
    ST_ERRO       = 4'hF
  } estado_t;

endpackage

// File: rtl/hcsr04_scheduler_if.sv
// -----------------------------------------------------------------------------
// hcsr04_scheduler_if
// Bundle between the measurement controller and its surroundings.
//   master : drives requests (medir, continuo) and datapath status
//            (pulso, fim_medida); observes the controller outputs.
//   slave  : the controller itself; drives zera/gera/registra to the
//            datapath and pronto/erro_timeout/ocupado/db_estado upward.
// -----------------------------------------------------------------------------
interface hcsr04_scheduler_if;
  import hcsr04_scheduler_pkg::*;

  logic             medir;
  logic             continuo;
  logic             pulso;
  logic             fim_medida;
  logic             zera;
  logic             gera;
  logic             registra;
  logic             pronto;
  logic             erro_timeout;
  logic             ocupado;
  logic [EST_W-1:0] db_estado;

  modport master (
    output medir, continuo, pulso, fim_medida,
    input  zera, gera, registra, pronto, erro_timeout, ocupado, db_estado
  );

  modport slave (
    input  medir, continuo, pulso, fim_medida,
    output zera, gera, registra, pronto, erro_timeout, ocupado, db_estado
  );

endinterface

// File: rtl/hcsr04_scheduler_contador.sv
// -----------------------------------------------------------------------------
// contador_m
// Unsigned up-counter with synchronous clear/enable and a terminal compare.
//   i_clock, i_reset : clock and synchronous active-high reset
//   i_clear          : force the count to zero (wins over i_enable)
//   i_enable         : increment by one
//   i_limite         : terminal value
//   o_fim            : count has reached the terminal value
// -----------------------------------------------------------------------------
module contador_m #(
  parameter int CW = 22
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_clear,
  input  logic          i_enable,
  input  logic [CW-1:0] i_limite,
  output logic          o_fim
);

  logic [CW-1:0] r_count;

  // Count register: reset, clear, increment or hold
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= {CW{1'b0}};
    end else if (i_clear) begin
      r_count <= {CW{1'b0}};
    end else if (i_enable) begin
      r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  // ">=" rather than "==": an echo arriving on the very last timeout cycle
  // moves to MEDIDA with the count already past the limit, and this still
  // forces the timeout instead of letting the counter wrap.
  assign o_fim = (r_count >= i_limite);

endmodule

// File: rtl/hcsr04_scheduler.sv
// -----------------------------------------------------------------------------
// hcsr04_scheduler
// Moore FSM sequencing one HC-SR04 measurement: clear datapath, fire trigger,
// wait for echo and measurement end (with timeout), latch result, then hold
// off before the next measurement. Single-shot (medir) or continuous
// (continuo) operation.
//   i_clock  : system clock
//   i_reset  : synchronous active-high reset
//   io_sched : slave side of hcsr04_scheduler_if (requests, datapath status,
//              datapath controls, status pulses, debug state)
// -----------------------------------------------------------------------------
module hcsr04_scheduler #(
  parameter int TIMEOUT_ECO = hcsr04_scheduler_pkg::TIMEOUT_ECO,
  parameter int INTERVALO   = hcsr04_scheduler_pkg::INTERVALO,
  parameter int CW          = hcsr04_scheduler_pkg::CW
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  hcsr04_scheduler_if.slave    io_sched
);
  import hcsr04_scheduler_pkg::*;

  estado_t       r_state;
  estado_t       w_next;
  logic          w_clear;
  logic          w_enable;
  logic [CW-1:0] w_limite;
  logic          w_fim;

  logic          w_zera;
  logic          w_gera;
  logic          w_registra;
  logic          w_pronto;
  logic          w_erro;

  // One counter serves both the echo timeout and the holdoff; the phases
  // never overlap, so the limit is just selected by state.
  contador_m #(.CW(CW)) u_contador (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .i_limite (w_limite),
    .o_fim    (w_fim)
  );

  // Counter control decoded from the current state
  always_comb begin
    w_clear  = 1'b0;
    w_enable = 1'b0;
    w_limite = CW'(TIMEOUT_ECO - 1);
    case (r_state)
      ST_PREPARA, ST_FINAL, ST_ERRO: w_clear = 1'b1;
      ST_TRIGGER, ST_ESPERA_ECO, ST_MEDIDA: w_enable = 1'b1;
      ST_INTERVALO: begin
        w_enable = 1'b1;
        w_limite = CW'(INTERVALO - 1);
      end
      default: w_clear = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_INICIAL;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INICIAL: begin
        if (io_sched.medir || io_sched.continuo) w_next = ST_PREPARA;
        else                                     w_next = ST_INICIAL;
      end
      ST_PREPARA:    w_next = ST_TRIGGER;
      ST_TRIGGER:    w_next = ST_ESPERA_ECO;
      ST_ESPERA_ECO: begin
        if (io_sched.pulso) w_next = ST_MEDIDA;
        else if (w_fim)     w_next = ST_ERRO;
        else                w_next = ST_ESPERA_ECO;
      end
      ST_MEDIDA: begin
        // A finished measurement beats a simultaneous timeout
        if (io_sched.fim_medida) w_next = ST_ARMAZENA;
        else if (w_fim)          w_next = ST_ERRO;
        else                     w_next = ST_MEDIDA;
      end
      ST_ARMAZENA:   w_next = ST_FINAL;
      ST_FINAL:      w_next = ST_INTERVALO;
      ST_ERRO:       w_next = ST_INTERVALO;
      ST_INTERVALO: begin
        if (!w_fim)                 w_next = ST_INTERVALO;
        else if (io_sched.continuo) w_next = ST_PREPARA;
        else                        w_next = ST_INICIAL;
      end
      default:       w_next = ST_INICIAL;
    endcase
  end

  // Moore outputs decoded from the state register only
  always_comb begin
    w_zera     = 1'b0;
    w_gera     = 1'b0;
    w_registra = 1'b0;
    w_pronto   = 1'b0;
    w_erro     = 1'b0;
    case (r_state)
      ST_PREPARA:  w_zera     = 1'b1;
      ST_TRIGGER:  w_gera     = 1'b1;
      ST_ARMAZENA: w_registra = 1'b1;
      ST_FINAL:    w_pronto   = 1'b1;
      ST_ERRO: begin
        w_erro = 1'b1;
        w_zera = 1'b1;
      end
      default:     w_zera     = 1'b0;
    endcase
  end

  assign io_sched.zera         = w_zera;
  assign io_sched.gera         = w_gera;
  assign io_sched.registra     = w_registra;
  assign io_sched.pronto       = w_pronto;
  assign io_sched.erro_timeout = w_erro;
  assign io_sched.ocupado      = (r_state != ST_INICIAL);
  assign io_sched.db_estado    = r_state;

endmodule

// File: tb/tb_hcsr04_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hcsr04_scheduler
// Self-checking bench. A timeline model builds the expected per-cycle output
// vector from phase lengths (trigger, echo delay, measurement length, timeout,
// holdoff) and compares it with the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_hcsr04_scheduler;

  localparam int TO   = 100;
  localparam int HO   = 20;
  localparam int MAXN = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hcsr04_scheduler_if bus();

  hcsr04_scheduler #(.TIMEOUT_ECO(TO), .INTERVALO(HO), .CW(22)) dut (
    .i_clock  (clk),
    .i_reset  (rst),
    .io_sched (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus per window cycle and expected {zera,gera,registra,pronto,erro,ocupado,db_estado}
  bit         stim_medir [MAXN];
  bit         stim_cont  [MAXN];
  bit         stim_pulso [MAXN];
  bit         stim_fim   [MAXN];
  logic [9:0] exp_v      [MAXN];
  int         eco_dly    [16];
  int         med_len    [16];
  int         rec_t      [16];
  int         rec_p      [16];
  int         exp_npronto;
  int         exp_nerro;
  int         obs_npronto, obs_nreg, obs_nerro;

  task automatic put(input int c, input logic [3:0] st, input logic [4:0] ev);
    if (c >= 0 && c < MAXN) exp_v[c] = {ev, (st != 4'h0), st};
  endtask

  task automatic clear_stim();
    for (int k = 0; k < MAXN; k++) begin
      stim_medir[k] = 1'b0;
      stim_cont[k]  = 1'b0;
    end
    for (int j = 0; j < 16; j++) begin
      eco_dly[j] = -1;
      med_len[j] = 1;
    end
  endtask

  // Timeline model: fills pulso/fim stimulus and expected outputs for n cycles
  task automatic model_run(input int n);
    int c, s, t, p, q, e, i, hi;
    bit ok;
    for (int k = 0; k < MAXN; k++) begin
      exp_v[k] = 10'b0; stim_pulso[k] = 1'b0; stim_fim[k] = 1'b0;
    end
    exp_npronto = 0; exp_nerro = 0; c = 0; i = 0;
    while (c < n) begin
      put(c, 4'h0, 5'b00000);
      if (stim_medir[c] || stim_cont[c]) begin
        s = c;
        do begin
          put(s + 1, 4'h1, 5'b10000);
          t = s + 2;
          put(t, 4'h2, 5'b01000);
          rec_t[i] = t;
          p = (eco_dly[i] >= 1 && eco_dly[i] <= TO - 10) ? t + eco_dly[i] : -1;
          rec_p[i] = p;
          q = 0;
          ok = 1'b0;
          if (p > 0) begin
            q  = p + med_len[i];
            ok = (q <= t + TO - 1);
            hi = ok ? q : t + TO;
            for (int k = p; k <= hi; k++) if (k < MAXN) stim_pulso[k] = 1'b1;
            if (ok && q < MAXN) stim_fim[q] = 1'b1;
            for (int k = t + 1; k <= p; k++) put(k, 4'h3, 5'b00000);
            hi = ok ? q : t + TO - 1;
            for (int k = p + 1; k <= hi; k++) put(k, 4'h4, 5'b00000);
          end else begin
            for (int k = t + 1; k <= t + TO - 1; k++) put(k, 4'h3, 5'b00000);
          end
          if (ok) begin
            put(q + 1, 4'h5, 5'b00100);
            e = q + 2;
            put(e, 4'h6, 5'b00010);
            exp_npronto++;
          end else begin
            e = t + TO;
            put(e, 4'hF, 5'b10001);
            exp_nerro++;
          end
          for (int k = e + 1; k <= e + HO; k++) put(k, 4'h7, 5'b00000);
          i++;
          s = e + HO;
        end while (s < MAXN && stim_cont[s] && i < 16);
        c = s + 1;
      end else begin
        c++;
      end
    end
  endtask

  // Drive the window stimulus and compare the output vector every cycle
  task automatic run_window(input string name, input int len);
    logic [9:0] obs;
    obs_npronto = 0; obs_nreg = 0; obs_nerro = 0;
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      bus.medir      = stim_medir[k];
      bus.continuo   = stim_cont[k];
      bus.pulso      = stim_pulso[k];
      bus.fim_medida = stim_fim[k];
      @(negedge clk);
      obs = {bus.zera, bus.gera, bus.registra, bus.pronto, bus.erro_timeout,
             bus.ocupado, bus.db_estado};
      if (obs[7]) obs_nreg++;
      if (obs[6]) obs_npronto++;
      if (obs[5]) obs_nerro++;
      n_checks++;
      if (obs !== exp_v[k]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %b, expected %b", name, k, obs, exp_v[k]);
      end
    end
  endtask

  task automatic idle(input int cycles);
    @(posedge clk); #1;
    bus.medir = 1'b0; bus.continuo = 1'b0; bus.pulso = 1'b0; bus.fim_medida = 1'b0;
    repeat (cycles) @(posedge clk);
  endtask

  task automatic check_count(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    rst = 1'b1;
    bus.medir = 1'b0; bus.continuo = 1'b0; bus.pulso = 1'b0; bus.fim_medida = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs = {bus.zera, bus.gera, bus.registra, bus.pronto, bus.erro_timeout,
           bus.ocupado, bus.db_estado};
    n_checks++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b, expected %b", obs, 10'b0);
    end
    rst = 1'b0;
    clear_stim();
    model_run(50);
    run_window("reset_idle", 50);
  endtask

  task automatic test_single();
    clear_stim();
    stim_medir[2] = 1'b1;
    eco_dly[0] = 10; med_len[0] = 30;
    model_run(150);
    run_window("single", 150);
    check_count("single_pronto_count", obs_npronto, exp_npronto);
    idle(2);
  endtask

  task automatic test_no_echo();
    clear_stim();
    stim_medir[2] = 1'b1;
    model_run(160);
    run_window("no_echo", 160);
    check_count("no_echo_registra_count", obs_nreg, 0);
    check_count("no_echo_erro_count", obs_nerro, 1);
    idle(2);
  endtask

  task automatic test_coincidence();
    clear_stim();
    stim_medir[2] = 1'b1;
    // fim_medida lands exactly when the timeout count reaches TO-1
    eco_dly[0] = 10; med_len[0] = TO - 1 - 10;
    model_run(160);
    run_window("coincidence", 160);
    check_count("coincidence_erro_count", obs_nerro, 0);
    check_count("coincidence_registra_count", obs_nreg, 1);
    idle(2);
  endtask

  task automatic test_continuous();
    int stop;
    clear_stim();
    for (int j = 0; j < 16; j++) begin
      eco_dly[j] = 5 + j; med_len[j] = 20 + 3 * j;
    end
    for (int k = 0; k < 300; k++) stim_cont[k] = 1'b1;
    model_run(300);
    // drop continuo inside the third MEDIDA; poke medir while busy
    stop = rec_p[2] + 2;
    for (int k = stop; k < MAXN; k++) stim_cont[k] = 1'b0;
    stim_medir[rec_t[0] + 5] = 1'b1;
    model_run(300);
    run_window("continuous", 300);
    check_count("continuous_pronto_count", obs_npronto, 3);
    check_count("continuous_model_count", obs_npronto, exp_npronto);
    idle(2);
  endtask

  task automatic test_reset_mid();
    logic [9:0] obs;
    clear_stim();
    stim_medir[2] = 1'b1;
    eco_dly[0] = 10; med_len[0] = 30;
    model_run(150);
    run_window("pre_reset", rec_p[0] + 3);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.medir = 1'b0; bus.pulso = 1'b0; bus.fim_medida = 1'b0; bus.continuo = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    obs = {bus.zera, bus.gera, bus.registra, bus.pronto, bus.erro_timeout,
           bus.ocupado, bus.db_estado};
    n_checks++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got %b, expected %b", obs, 10'b0);
    end
    clear_stim();
    stim_medir[3] = 1'b1;
    eco_dly[0] = $urandom_range(1, 60); med_len[0] = $urandom_range(1, 30);
    model_run(150);
    run_window("after_reset", 150);
    idle(2);
  endtask

  task automatic test_back_to_back();
    int last;
    for (int r = 0; r < 3; r++) begin
      clear_stim();
      for (int j = 0; j < 16; j++) begin
        eco_dly[j] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 80));
        med_len[j] = $urandom_range(1, 120);
      end
      last = $urandom_range(100, 300);
      for (int k = 1; k <= last; k++) stim_medir[k] = 1'b1;
      model_run(500);
      run_window("back_to_back", 500);
      check_count("back_to_back_pronto", obs_npronto, exp_npronto);
      check_count("back_to_back_erro", obs_nerro, exp_nerro);
      idle(2);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_no_echo();
    test_coincidence();
    test_continuous();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
